blur_frame_scheduler: RTL and testbench

- Shares one frame-buffered blur engine between two pixel sources: source 0 is the camera path and source 1 is the host/test-pattern path.
- Grants one whole frame at a time using round-robin arbitration.
- Latches and clamps the granted source's blur radius, then streams that source's frame into the engine.
- Counts the blurred frame back out, tags each output pixel with its owner, and recovers from a stalled engine by timeout.

---
 rtl/blur_frame_scheduler_if.sv | 46 ++++
 rtl/blur_frame_scheduler.sv | 146 ++++++++++++++
 tb/tb_blur_frame_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/blur_frame_scheduler_if.sv
// Bundles the two pixel sources, the blur engine link and the result stream.
// Latency: none, wires only.
// Backpressure: src_ready per source; the engine and result paths are strobe-only.
interface blur_frame_scheduler_if #(
    parameter int DATA_WIDTH = 8,
    parameter int RADIUS_W   = 3
);
    logic [1:0]            req;
    logic [1:0]            grant;
    logic [DATA_WIDTH-1:0] src0_pixel;
    logic                  src0_valid;
    logic [RADIUS_W-1:0]   src0_radius;
    logic [DATA_WIDTH-1:0] src1_pixel;
    logic                  src1_valid;
    logic [RADIUS_W-1:0]   src1_radius;
    logic [1:0]            src_ready;
    logic [DATA_WIDTH-1:0] eng_pixel_in;
    logic                  eng_pixel_in_valid;
    logic [RADIUS_W-1:0]   eng_radius;
    logic                  eng_busy;
    logic [DATA_WIDTH-1:0] eng_pixel_out;
    logic                  eng_pixel_out_valid;
    logic [DATA_WIDTH-1:0] out_pixel;
    logic                  out_valid;
    logic                  out_owner;
    logic                  frame_done;
    logic                  timeout_err;

    // Environment side: sources, engine model and result consumer.
    modport master (
        output req, src0_pixel, src0_valid, src0_radius,
        output src1_pixel, src1_valid, src1_radius,
        output eng_busy, eng_pixel_out, eng_pixel_out_valid,
        input  grant, src_ready, eng_pixel_in, eng_pixel_in_valid, eng_radius,
        input  out_pixel, out_valid, out_owner, frame_done, timeout_err
    );

    // Scheduler side.
    modport slave (
        input  req, src0_pixel, src0_valid, src0_radius,
        input  src1_pixel, src1_valid, src1_radius,
        input  eng_busy, eng_pixel_out, eng_pixel_out_valid,
        output grant, src_ready, eng_pixel_in, eng_pixel_in_valid, eng_radius,
        output out_pixel, out_valid, out_owner, frame_done, timeout_err
    );
endinterface

// File: rtl/blur_frame_scheduler.sv
// Round-robin frame scheduler sharing one blur engine between two pixel sources.
// Latency: grant 1 cycle after request; source->engine and engine->output 1 cycle each.
// Backpressure: src_ready for the owner only during load; engine stall aborts via timeout.
module blur_frame_scheduler #(
    parameter int IMG_WIDTH      = 640,
    parameter int IMG_HEIGHT     = 480,
    parameter int DATA_WIDTH     = 8,
    parameter int MAX_RADIUS     = 4,
    parameter int RADIUS_W       = 3,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input logic clk,
    input logic reset,
    blur_frame_scheduler_if.slave bus
);
    localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]       LAST     = CW'(TOTAL - 1);
    localparam logic [TW-1:0]       TO_LIMIT = TW'(TIMEOUT_CYCLES);
    localparam logic [RADIUS_W-1:0] MAX_R    = RADIUS_W'(MAX_RADIUS);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_OUT, DRAIN} state_t;

    state_t                state;
    logic [CW-1:0]         in_cnt;
    logic [CW-1:0]         out_cnt;
    logic [TW-1:0]         to_cnt;
    logic                  prio;
    logic                  owner_r;
    logic [1:0]            grant_r;
    logic [1:0]            ready_r;
    logic [DATA_WIDTH-1:0] eng_pix_r;
    logic                  eng_vld_r;
    logic [RADIUS_W-1:0]   radius_r;
    logic [DATA_WIDTH-1:0] out_pix_r;
    logic                  out_vld_r;
    logic                  done_r;
    logic                  to_err_r;

    logic                  pick;
    logic [RADIUS_W-1:0]   pick_radius;
    logic                  own_valid;
    logic [DATA_WIDTH-1:0] own_pixel;
    logic                  load_xfer;
    logic [TW-1:0]         to_nxt;

    // Arbitration choice and owner-side source mux.
    always_comb begin
        pick        = (bus.req == 2'b11) ? prio : bus.req[1];
        pick_radius = pick ? bus.src1_radius : bus.src0_radius;
        own_valid   = owner_r ? bus.src1_valid : bus.src0_valid;
        own_pixel   = owner_r ? bus.src1_pixel : bus.src0_pixel;
        load_xfer   = (state == LOAD) && own_valid && ready_r[owner_r];
        to_nxt      = to_cnt + TW'(1);
    end

    // Frame FSM: grant, load the engine, drain results or give up on timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            in_cnt    <= '0;
            out_cnt   <= '0;
            to_cnt    <= '0;
            prio      <= 1'b0;
            owner_r   <= 1'b0;
            grant_r   <= 2'b00;
            ready_r   <= 2'b00;
            eng_pix_r <= '0;
            eng_vld_r <= 1'b0;
            radius_r  <= '0;
            out_pix_r <= '0;
            out_vld_r <= 1'b0;
            done_r    <= 1'b0;
            to_err_r  <= 1'b0;
        end else begin
            eng_vld_r <= 1'b0;
            out_vld_r <= 1'b0;
            done_r    <= 1'b0;
            to_err_r  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req != 2'b00 && !bus.eng_busy) begin
                        grant_r  <= pick ? 2'b10 : 2'b01;
                        ready_r  <= pick ? 2'b10 : 2'b01;
                        owner_r  <= pick;
                        prio     <= ~pick;
                        radius_r <= (pick_radius > MAX_R) ? MAX_R : pick_radius;
                        in_cnt   <= '0;
                        out_cnt  <= '0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (load_xfer) begin
                        eng_pix_r <= own_pixel;
                        eng_vld_r <= 1'b1;
                        in_cnt    <= in_cnt + CW'(1);
                        if (in_cnt == LAST) begin
                            ready_r <= 2'b00;
                            to_cnt  <= '0;
                            state   <= WAIT_OUT;
                        end
                    end
                end
                WAIT_OUT, DRAIN: begin
                    if (bus.eng_pixel_out_valid) begin
                        out_pix_r <= bus.eng_pixel_out;
                        out_vld_r <= 1'b1;
                        out_cnt   <= out_cnt + CW'(1);
                        to_cnt    <= '0;
                        state     <= DRAIN;
                        if (out_cnt == LAST) begin
                            done_r  <= 1'b1;
                            grant_r <= 2'b00;
                            in_cnt  <= '0;
                            out_cnt <= '0;
                            state   <= IDLE;
                        end
                    end else if (to_nxt == TO_LIMIT) begin
                        to_err_r <= 1'b1;
                        grant_r  <= 2'b00;
                        in_cnt   <= '0;
                        out_cnt  <= '0;
                        to_cnt   <= '0;
                        state    <= IDLE;
                    end else begin
                        to_cnt <= to_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant              = grant_r;
    assign bus.src_ready          = ready_r;
    assign bus.eng_pixel_in       = eng_pix_r;
    assign bus.eng_pixel_in_valid = eng_vld_r;
    assign bus.eng_radius         = radius_r;
    assign bus.out_pixel          = out_pix_r;
    assign bus.out_valid          = out_vld_r;
    assign bus.out_owner          = owner_r;
    assign bus.frame_done         = done_r;
    assign bus.timeout_err        = to_err_r;
endmodule

// File: tb/tb_blur_frame_scheduler.sv
// Bench for blur_frame_scheduler on a 4x2 frame with a 50-cycle engine timeout.
// Latency: checks every cycle against a frame-level model plus literal expectations.
// Backpressure: sources honour src_ready; engine model echoes +1 or stays silent.
module tb_blur_frame_scheduler;
    localparam int DW = 8, RW = 3, TOT = 8, TO = 50, MAXR = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    blur_frame_scheduler_if #(.DATA_WIDTH(DW), .RADIUS_W(RW)) ifc ();

    blur_frame_scheduler #(
        .IMG_WIDTH(4), .IMG_HEIGHT(2), .DATA_WIDTH(DW), .MAX_RADIUS(MAXR),
        .RADIUS_W(RW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(ifc)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- source drivers ----------------
    logic [7:0] s_base0 = 0, s_base1 = 0;
    bit s_en0 = 0, s_en1 = 0, s_tog0 = 0;
    initial begin
        bit took0, took1, ph0;
        logic [7:0] cnt0, cnt1;
        cnt0 = 0; cnt1 = 0; ph0 = 0;
        ifc.src0_valid = 0; ifc.src0_pixel = 0;
        ifc.src1_valid = 0; ifc.src1_pixel = 0;
        forever begin
            @(negedge clk);
            took0 = ifc.src0_valid && ifc.src_ready[0];
            took1 = ifc.src1_valid && ifc.src_ready[1];
            @(posedge clk); #1;
            if (!s_en0) cnt0 = 0; else if (took0) cnt0++;
            if (!s_en1) cnt1 = 0; else if (took1) cnt1++;
            ph0 = ~ph0;
            ifc.src0_pixel = s_base0 + cnt0;
            ifc.src0_valid = s_en0 && (!s_tog0 || ph0);
            ifc.src1_pixel = s_base1 + cnt1;
            ifc.src1_valid = s_en1;
        end
    end

    // ---------------- engine model ----------------
    int eng_mode = 1;   // 1: echo +1 about 20 cycles after a full frame, 0: never answer
    initial begin
        logic [7:0] eq[$];
        ifc.eng_pixel_out_valid = 0;
        ifc.eng_pixel_out = 0;
        forever begin
            @(negedge clk);
            if (reset) eq.delete();
            else begin
                if (ifc.eng_pixel_in_valid) eq.push_back(ifc.eng_pixel_in);
                if (eq.size() == TOT) begin
                    if (eng_mode == 0) eq.delete();
                    else begin
                        repeat (20) @(posedge clk);
                        for (int i = 0; i < TOT; i++) begin
                            @(posedge clk); #1;
                            ifc.eng_pixel_out_valid = 1;
                            ifc.eng_pixel_out = eq.pop_front() + 8'd1;
                        end
                        @(posedge clk); #1;
                        ifc.eng_pixel_out_valid = 0;
                    end
                end
            end
        end
    end

    // ---------------- capture of actual activity ----------------
    logic [7:0] cap_in[$], cap_out[$];
    int n_done = 0, n_to = 0, cyc = 0, t8 = 0, tto = 0;
    bit r1_bad = 0;
    initial forever begin
        @(negedge clk);
        cyc++;
        if (ifc.eng_pixel_in_valid) begin
            cap_in.push_back(ifc.eng_pixel_in);
            if (cap_in.size() == TOT) t8 = cyc;
        end
        if (ifc.out_valid) cap_out.push_back(ifc.out_pixel);
        if (ifc.frame_done) n_done++;
        if (ifc.timeout_err) begin n_to++; tto = cyc; end
        if (ifc.grant == 2'b01 && ifc.src_ready[1]) r1_bad = 1;
    end

    // ---------------- frame-level model and per-cycle compare ----------------
    int m_busy_frame, m_loading, m_owner, m_rr, m_loaded, m_ret, m_idle, m_radius, r;
    bit e_in_vld, e_out_vld, e_done, e_to;
    logic [7:0] e_in_pix, e_out_pix;
    initial forever begin
        @(negedge clk);
        if (reset) begin
            m_busy_frame = 0; m_loading = 0; m_owner = 0; m_rr = 0;
            m_loaded = 0; m_ret = 0; m_idle = 0; m_radius = 0;
            e_in_vld = 0; e_out_vld = 0; e_done = 0; e_to = 0;
            e_in_pix = 0; e_out_pix = 0;
            chk("rst grant", ifc.grant, 0);
            chk("rst src_ready", ifc.src_ready, 0);
            chk("rst eng_in_valid", ifc.eng_pixel_in_valid, 0);
            chk("rst eng_in", ifc.eng_pixel_in, 0);
            chk("rst eng_radius", ifc.eng_radius, 0);
            chk("rst out_valid", ifc.out_valid, 0);
            chk("rst out_pixel", ifc.out_pixel, 0);
            chk("rst out_owner", ifc.out_owner, 0);
            chk("rst frame_done", ifc.frame_done, 0);
            chk("rst timeout_err", ifc.timeout_err, 0);
        end else begin
            chk("grant", ifc.grant, m_busy_frame ? (32'd1 << m_owner) : 32'd0);
            chk("src_ready", ifc.src_ready, m_loading ? (32'd1 << m_owner) : 32'd0);
            chk("eng_in_valid", ifc.eng_pixel_in_valid, e_in_vld);
            if (e_in_vld) chk("eng_in", ifc.eng_pixel_in, e_in_pix);
            chk("eng_radius", ifc.eng_radius, m_radius);
            chk("out_valid", ifc.out_valid, e_out_vld);
            if (e_out_vld) chk("out_pixel", ifc.out_pixel, e_out_pix);
            chk("out_owner", ifc.out_owner, m_owner);
            chk("frame_done", ifc.frame_done, e_done);
            chk("timeout_err", ifc.timeout_err, e_to);

            // What the next edge must produce, from the current inputs.
            e_in_vld = 0; e_out_vld = 0; e_done = 0; e_to = 0;
            if (!m_busy_frame) begin
                if (ifc.req != 0 && !ifc.eng_busy) begin
                    m_owner = (ifc.req == 2'b11) ? m_rr : (ifc.req[1] ? 1 : 0);
                    m_rr = 1 - m_owner;
                    r = m_owner ? int'(ifc.src1_radius) : int'(ifc.src0_radius);
                    m_radius = (r > MAXR) ? MAXR : r;
                    m_busy_frame = 1; m_loading = 1; m_loaded = 0; m_ret = 0;
                end
            end else if (m_loading) begin
                if (m_owner ? ifc.src1_valid : ifc.src0_valid) begin
                    e_in_vld = 1;
                    e_in_pix = m_owner ? ifc.src1_pixel : ifc.src0_pixel;
                    m_loaded++;
                    if (m_loaded == TOT) begin m_loading = 0; m_idle = 0; end
                end
            end else begin
                if (ifc.eng_pixel_out_valid) begin
                    e_out_vld = 1; e_out_pix = ifc.eng_pixel_out;
                    m_ret++; m_idle = 0;
                    if (m_ret == TOT) begin e_done = 1; m_busy_frame = 0; end
                end else begin
                    m_idle++;
                    if (m_idle == TO) begin e_to = 1; m_busy_frame = 0; end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic wait_grant(input int budget, input string name);
        int n = 0;
        do begin step(); n++; end while (ifc.grant == 0 && n < budget);
        chk(name, ifc.grant != 0, 1);
    endtask

    task automatic wait_done(input int d0, input int budget, input string name);
        int n = 0;
        do begin step(); n++; end while (n_done == d0 && n < budget);
        chk(name, n_done > d0, 1);
    endtask

    task automatic do_reset();
        reset = 1; step(); step(); reset = 0;
    endtask

    task automatic clear_caps();
        cap_in.delete(); cap_out.delete();
    endtask

    int d0;
    logic [1:0] gseq[3];

    initial begin
        ifc.req = 0; ifc.src0_radius = 0; ifc.src1_radius = 0; ifc.eng_busy = 0;
        reset = 1;
        repeat (3) step();
        chk("reset grant literal", ifc.grant, 0);
        chk("reset out_owner literal", ifc.out_owner, 0);
        reset = 0;

        // Single source-0 frame, engine busy holds off the grant first.
        s_base0 = 10; s_en0 = 1; ifc.src0_radius = 2; ifc.eng_busy = 1; ifc.req = 2'b01;
        repeat (3) step();
        chk("t1 busy blocks grant", ifc.grant, 0);
        ifc.eng_busy = 0; clear_caps(); d0 = n_done;
        wait_grant(20, "t1 grant arrives");
        chk("t1 grant", ifc.grant, 2'b01);
        chk("t1 radius", ifc.eng_radius, 2);
        ifc.req = 0;
        wait_done(d0, 200, "t1 frame_done arrives");
        step();
        chk("t1 in count", cap_in.size(), 8);
        for (int i = 0; i < 8; i++) chk("t1 in pixel", cap_in[i], 10 + i);
        for (int i = 0; i < 8; i++) chk("t1 out pixel", cap_out[i], 11 + i);
        chk("t1 one frame_done", n_done - d0, 1);
        chk("t1 grant released", ifc.grant, 0);
        s_en0 = 0; step();

        // Three frames with both sources requesting, radius clamp on source 1.
        do_reset();
        s_base0 = 20; s_base1 = 40; s_en0 = 1; s_en1 = 1;
        ifc.src0_radius = 3; ifc.src1_radius = 7; r1_bad = 0; clear_caps();
        ifc.req = 2'b11;
        for (int f = 0; f < 3; f++) begin
            d0 = n_done;
            wait_grant(50, "t2 grant arrives");
            gseq[f] = ifc.grant;
            if (ifc.grant == 2'b10) begin
                chk("t2 clamped radius", ifc.eng_radius, 4);
                repeat (3) step();
                ifc.src1_radius = 1;
                step();
                chk("t2 radius held", ifc.eng_radius, 4);
            end
            wait_done(d0, 200, "t2 frame_done arrives");
        end
        ifc.req = 0;
        chk("t2 grant 0", gseq[0], 2'b01);
        chk("t2 grant 1", gseq[1], 2'b10);
        chk("t2 grant 2", gseq[2], 2'b01);
        chk("t2 ready1 in src0 frame", r1_bad, 0);
        chk("t2 in count", cap_in.size(), 24);
        chk("t2 f0 first", cap_in[0], 20);
        chk("t2 f1 first", cap_in[8], 40);
        chk("t2 f1 last", cap_in[15], 47);
        chk("t2 f2 first", cap_in[16], 28);
        s_en0 = 0; s_en1 = 0; step();

        // Silent engine: timeout, then the pending source-0 request is served.
        eng_mode = 0; s_base0 = 50; s_base1 = 70; s_en0 = 1; s_en1 = 1;
        clear_caps(); d0 = n_done; ifc.req = 2'b11;
        wait_grant(20, "t4 grant arrives");
        chk("t4 first grant", ifc.grant, 2'b10);
        ifc.req = 2'b01;
        begin
            int n = 0, to0 = n_to;
            do begin step(); n++; end while (n_to == to0 && n < 200);
            chk("t4 timeout arrives", n_to > to0, 1);
        end
        chk("t4 timeout latency", tto - t8, 50);
        chk("t4 no frame_done", n_done - d0, 0);
        eng_mode = 1;
        wait_grant(20, "t4 next grant arrives");
        chk("t4 next grant", ifc.grant, 2'b01);
        ifc.req = 0;
        wait_done(d0, 200, "t4 frame_done arrives");
        chk("t4 src0 frame first", cap_in[8], 50);
        chk("t4 src0 frame last", cap_in[15], 57);
        s_en0 = 0; s_en1 = 0; step();

        // Gappy source 0 with a spurious source-1 valid.
        s_base0 = 80; s_base1 = 200; s_tog0 = 1; s_en0 = 1; s_en1 = 1;
        clear_caps(); d0 = n_done; ifc.req = 2'b01;
        wait_grant(20, "t5 grant arrives");
        ifc.req = 0;
        wait_done(d0, 200, "t5 frame_done arrives");
        step();
        chk("t5 in count", cap_in.size(), 8);
        for (int i = 0; i < 8; i++) chk("t5 in pixel", cap_in[i], 80 + i);
        s_tog0 = 0; s_en0 = 0; s_en1 = 0; step();

        // Reset in the middle of loading, then a clean frame.
        s_base0 = 90; s_en0 = 1; clear_caps(); ifc.req = 2'b01;
        wait_grant(20, "t6 grant arrives");
        ifc.req = 0;
        begin
            int n = 0;
            do begin step(); n++; end while (cap_in.size() < 5 && n < 100);
            chk("t6 five pixels loaded", cap_in.size() >= 5, 1);
        end
        #1 reset = 1;
        #1;
        chk("t6 async grant", ifc.grant, 0);
        chk("t6 async src_ready", ifc.src_ready, 0);
        chk("t6 async eng_in_valid", ifc.eng_pixel_in_valid, 0);
        chk("t6 async eng_radius", ifc.eng_radius, 0);
        chk("t6 async out_owner", ifc.out_owner, 0);
        s_en0 = 0;
        step(); step();
        reset = 0;
        step();
        s_base0 = 100; s_en0 = 1; clear_caps(); d0 = n_done; ifc.req = 2'b01;
        wait_grant(20, "t6 regrant arrives");
        chk("t6 regrant", ifc.grant, 2'b01);
        ifc.req = 0;
        wait_done(d0, 200, "t6 frame_done arrives");
        step();
        chk("t6 in count", cap_in.size(), 8);
        chk("t6 first pixel", cap_in[0], 100);
        chk("t6 last pixel", cap_in[7], 107);
        chk("t6 last out", cap_out[7], 108);
        s_en0 = 0;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end
endmodule
